// File: rtl/vr_tx_fifo.sv
// Buffered valid/ready byte source: a DEPTH-entry FIFO with occupancy reporting.
// Define VR_TX_OVF_CNT_EN to add the saturating dropped-write counter ovf_cnt_o.
module vr_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     full_o,
    output logic                     valid_o,
    output logic [DATA_W-1:0]        data_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef VR_TX_OVF_CNT_EN
    ,
    output logic [7:0]               ovf_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;

    logic [PW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == PW'(DEPTH));
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = wr_en_i && !w_full;
    assign w_pop   = !w_empty && ready_i;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    assign full_o  = w_full;
    assign valid_o = !w_empty;
    assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign count_o = w_count;

`ifdef VR_TX_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (wr_en_i && w_full && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt_o = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_vr_tx_fifo.sv
// Self-checking bench for vr_tx_fifo: directed scenarios plus random traffic
// compared each cycle against a queue-based occupancy model.
module tb_vr_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic [PW-1:0]     count;
`ifdef VR_TX_OVF_CNT_EN
    logic [7:0]        ovf_cnt;
`endif

    vr_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .full_o    (full),
        .valid_o   (valid),
        .data_o    (data),
        .ready_i   (ready),
        .count_o   (count)
`ifdef VR_TX_OVF_CNT_EN
        ,
        .ovf_cnt_o (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mdl_q [$];
    logic [DATA_W-1:0] dut_log [$];
    logic [DATA_W-1:0] pushed [$];
    int                mdl_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        logic [DATA_W-1:0] exp_d;
        exp_d = (mdl_q.size() > 0) ? mdl_q[0] : '0;
        chk("valid", 32'(valid), 32'(mdl_q.size() > 0));
        chk("data",  32'(data),  32'(exp_d));
        chk("count", 32'(count), 32'(mdl_q.size()));
        chk("full",  32'(full),  32'(mdl_q.size() == DEPTH));
`ifdef VR_TX_OVF_CNT_EN
        chk("ovf",   32'(ovf_cnt), 32'(mdl_ovf));
`endif
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance model at posedge.
    task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rdy);
        bit can_push;
        logic [DATA_W-1:0] tmp;
        wr_en   = wr;
        wr_data = d;
        ready   = rdy;
        @(negedge clk);
        chk_model();
        if (valid && ready) dut_log.push_back(data);
        @(posedge clk);
        can_push = (mdl_q.size() < DEPTH);
        if (mdl_q.size() > 0 && rdy) tmp = mdl_q.pop_front();
        if (wr && can_push) begin
            mdl_q.push_back(d);
            pushed.push_back(d);
        end else if (wr && mdl_ovf < 255) begin
            mdl_ovf++;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        ready   = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data",  32'(data),  32'd0);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
`ifdef VR_TX_OVF_CNT_EN
        chk("rst_ovf",   32'(ovf_cnt), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Three bytes streamed through with the consumer always ready
        dut_log.delete();
        step(1'b1, 8'h11, 1'b1);
        chk("lat_valid", 32'(valid), 32'd1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_n",   32'(dut_log.size()), 32'd3);
        if (dut_log.size() == 3) begin
            chk("t1_b0", 32'(dut_log[0]), 32'h11);
            chk("t1_b1", 32'(dut_log[1]), 32'h22);
            chk("t1_b2", 32'(dut_log[2]), 32'h33);
        end
        chk("t1_cnt", 32'(count), 32'd0);

        // Fill under back-pressure, then one dropped write
        dut_log.delete();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        chk("t2_full", 32'(full),  32'd1);
        chk("t2_cnt",  32'(count), 32'(DEPTH));
        step(1'b1, 8'hAA, 1'b0);
        chk("t2_cnt_after_drop", 32'(count), 32'(DEPTH));
`ifdef VR_TX_OVF_CNT_EN
        chk("t2_ovf", 32'(ovf_cnt), 32'd1);
`endif
        drain();
        chk("t2_n", 32'(dut_log.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < dut_log.size(); i++)
            chk("t2_byte", 32'(dut_log[i]), 32'(i));

        // Head held stable under back-pressure
        step(1'b1, 8'h5C, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("t3_valid", 32'(valid), 32'd1);
            chk("t3_data",  32'(data),  32'h5C);
            chk("t3_cnt",   32'(count), 32'd1);
        end
        drain();

        // Steady occupancy of 4 with simultaneous push and pop
        dut_log.delete();
        pushed.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            chk("t4_cnt", 32'(count), 32'd4);
        end
        chk("t4_n", 32'(dut_log.size()), 32'd20);
        for (int i = 0; i < 20 && i < dut_log.size(); i++)
            chk("t4_seq", 32'(dut_log[i]), 32'(pushed[i]));
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // Asynchronous reset with 5 entries stored
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(valid), 32'd0);
        chk("t5_full",  32'(full),  32'd0);
        chk("t5_cnt",   32'(count), 32'd0);
        chk("t5_data",  32'(data),  32'd0);
        mdl_q.delete();
        mdl_ovf = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        dut_log.delete();
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("t5_n", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("t5_first", 32'(dut_log[0]), 32'h99);
        drain();

        // Many writes while full: counter saturation
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b0);
        chk("t6_full", 32'(full), 32'd1);
`ifdef VR_TX_OVF_CNT_EN
        chk("t6_ovf_sat", 32'(ovf_cnt), 32'd255);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
